// File: rtl/micro_sequencer.sv
// Micro-sequencer: accepts a decoded index, fetches one control word, issues it for N beats.
// Optional macro USEQ_RANGE_CHECK_EN rejects out-of-range indices with an illegal pulse.
module micro_sequencer #(
  parameter int WIDTH     = 16,
  parameter int ADDR_W    = 6,
  parameter int MUL_BEATS = 4,
  parameter int MUL_IDX   = 31,
  parameter int COPY_IDX  = 32,
  parameter int MAX_IDX   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [ADDR_W-1:0] instr_idx,
  input  logic [7:0]        copy_len,
  output logic [ADDR_W-1:0] uaddr,
  input  logic [WIDTH-1:0]  udata,
  output logic              ctrl_valid,
  input  logic              ctrl_ready,
  output logic [WIDTH-1:0]  ctrl_word,
  output logic [7:0]        beat_idx,
  output logic              ctrl_last,
  output logic              illegal
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    ISSUE
  } state_t;

  localparam logic [ADDR_W-1:0] MUL_A  = ADDR_W'(MUL_IDX);
  localparam logic [ADDR_W-1:0] COPY_A = ADDR_W'(COPY_IDX);

  state_t     state;
  state_t     state_nx;
  logic       run;
  logic [7:0] beats;
  logic [7:0] beats_sel;
  logic       accept;
  logic       bad;
  logic       take;
  logic       step;

  // run keeps instr_ready low until the first edge after reset release
  assign instr_ready = run && (state == IDLE);
  assign accept      = instr_valid && instr_ready;
  assign take        = accept && !bad;
  assign ctrl_valid  = (state == ISSUE);
  assign ctrl_last   = ctrl_valid && (beat_idx == beats - 8'd1);
  assign step        = ctrl_valid && ctrl_ready;

`ifdef USEQ_RANGE_CHECK_EN
  localparam int unsigned MAX_U = MAX_IDX;

  assign bad = 32'(instr_idx) > MAX_U;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal <= 1'b0;
    end else begin
      illegal <= accept && bad;
    end
  end
`else
  assign bad     = 1'b0;
  assign illegal = 1'b0;
`endif

  always_comb begin
    beats_sel = 8'd1;
    unique case (1'b1)
      (instr_idx == MUL_A):  beats_sel = 8'(MUL_BEATS);
      (instr_idx == COPY_A): beats_sel = copy_len;
      default:               beats_sel = 8'd1;
    endcase
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (take) state_nx = FETCH;
      FETCH:   state_nx = (beats == 8'd0) ? IDLE : ISSUE;
      ISSUE:   if (step && ctrl_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      run       <= 1'b0;
      uaddr     <= '0;
      beats     <= 8'd0;
      beat_idx  <= 8'd0;
      ctrl_word <= '0;
    end else begin
      state <= state_nx;
      run   <= 1'b1;
      if (take) begin
        uaddr    <= instr_idx;
        beats    <= beats_sel;
        beat_idx <= 8'd0;
      end
      if (state == FETCH) ctrl_word <= udata;
      if (step && !ctrl_last) beat_idx <= beat_idx + 8'd1;
    end
  end

endmodule

// File: tb/tb_micro_sequencer.sv
// Scoreboard bench for micro_sequencer: stimulus queues expected beats,
// a negedge monitor pops and compares them on every valid cycle.
module tb_micro_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [5:0]  instr_idx = '0;
  logic [7:0]  copy_len = '0;
  logic [5:0]  uaddr;
  logic [15:0] udata;
  logic        ctrl_valid;
  logic        ctrl_ready = 1'b1;
  logic [15:0] ctrl_word;
  logic [7:0]  beat_idx;
  logic        ctrl_last;
  logic        illegal;

  int n_run = 0;
  int n_fail = 0;

  typedef struct {
    logic [15:0] w;
    logic [7:0]  i;
    logic        l;
  } exp_t;

  exp_t exp_q[$];
  bit   rdy_q[$];

  always #5 clk = ~clk;

  micro_sequencer dut (
    .clk(clk),
    .rst_n(rst_n),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr_idx(instr_idx),
    .copy_len(copy_len),
    .uaddr(uaddr),
    .udata(udata),
    .ctrl_valid(ctrl_valid),
    .ctrl_ready(ctrl_ready),
    .ctrl_word(ctrl_word),
    .beat_idx(beat_idx),
    .ctrl_last(ctrl_last),
    .illegal(illegal)
  );

  function automatic logic [15:0] rom(input logic [5:0] a);
    case (a)
      6'd0:    return 16'h1000;
      6'd19:   return 16'hD801;
      6'd31:   return 16'h1340;
      6'd32:   return 16'h0C07;
      default: return 16'hA000 | 16'(a);
    endcase
  endfunction

  assign udata = rom(uaddr);

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
    n_run++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, req);
    end
  endtask

  task automatic push(input logic [15:0] w, input int n);
    for (int k = 0; k < n; k++)
      exp_q.push_back('{w: w, i: 8'(k), l: (k == n - 1)});
  endtask

  always @(posedge clk) begin
    #1;
    if (ctrl_valid && rdy_q.size() > 0) ctrl_ready = rdy_q.pop_front();
    else ctrl_ready = 1'b1;
  end

  // monitor: every valid cycle must match the head of the queue
  always @(negedge clk) begin
    if (rst_n) begin
      if (ctrl_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", {16'd0, ctrl_word}, 32'hFFFF_FFFF);
        end else begin
          check("ctrl_word", 32'(ctrl_word), 32'(exp_q[0].w));
          check("beat_idx", 32'(beat_idx), 32'(exp_q[0].i));
          check("ctrl_last", 32'(ctrl_last), 32'(exp_q[0].l));
          if (ctrl_ready) void'(exp_q.pop_front());
        end
      end else begin
        check("last_idle", 32'(ctrl_last), 32'd0);
      end
    end
  end

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      ok = instr_ready && !ctrl_valid;
    end
    check("idle_timeout", 32'(ok), 32'd1);
  endtask

  task automatic issue(input logic [5:0] idx, input logic [7:0] len,
                       input int nb, input bit bad);
    wait_idle();
    instr_idx = idx;
    copy_len = len;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    check("fetch_no_valid", 32'(ctrl_valid), 32'd0);
    check("illegal_pulse", 32'(illegal), 32'(bad));
    check("ready_after_acc", 32'(instr_ready), 32'(bad));
    @(negedge clk);
    check("valid_latency", 32'(ctrl_valid), 32'(nb > 0));
    check("illegal_clear", 32'(illegal), 32'd0);
    wait_idle();
    check("drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_zero(input string nm);
    check({nm, "_valid"}, 32'(ctrl_valid), 32'd0);
    check({nm, "_word"}, 32'(ctrl_word), 32'd0);
    check({nm, "_beat"}, 32'(beat_idx), 32'd0);
    check({nm, "_last"}, 32'(ctrl_last), 32'd0);
    check({nm, "_illegal"}, 32'(illegal), 32'd0);
    check({nm, "_ready"}, 32'(instr_ready), 32'd0);
    check({nm, "_uaddr"}, 32'(uaddr), 32'd0);
  endtask

  initial begin
    bit hit;
    #3 check_zero("rst");
    #20 rst_n = 1'b1;
    #1 check("ready_pre_edge", 32'(instr_ready), 32'd0);
    @(negedge clk);
    check("ready_post_rst", 32'(instr_ready), 32'd1);

    push(16'h1000, 1);
    issue(6'd0, 8'd0, 1, 1'b0);

    rdy_q = '{1'b0, 1'b0, 1'b0, 1'b1};
    push(16'hD801, 1);
    issue(6'd19, 8'd0, 1, 1'b0);

    push(16'h1340, 4);
    issue(6'd31, 8'd0, 4, 1'b0);

    rdy_q = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    push(16'h0C07, 3);
    issue(6'd32, 8'd3, 3, 1'b0);

    issue(6'd32, 8'd0, 0, 1'b0);

    push(16'hA005, 1);
    issue(6'd5, 8'd0, 1, 1'b0);

`ifdef USEQ_RANGE_CHECK_EN
    issue(6'd40, 8'd0, 0, 1'b1);
    check("uaddr_hold", 32'(uaddr), 32'd5);
`else
    push(16'hA028, 1);
    issue(6'd40, 8'd0, 1, 1'b0);
    check("uaddr_any", 32'(uaddr), 32'd40);
`endif

    // reset in the middle of a MUL sequence
    wait_idle();
    push(16'h1340, 4);
    instr_idx = 6'd31;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(posedge clk);
      #1 hit = ctrl_valid && (beat_idx == 8'd2);
    end
    check("reach_beat2", 32'(hit), 32'd1);
    #1 rst_n = 1'b0;
    exp_q.delete();
    #1 check_zero("mid_rst");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("ready_after_mid", 32'(instr_ready), 32'd1);
    check("no_beats_after", 32'(ctrl_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/micro_sequencer.md
MICRO_SEQUENCER -- requirements
Module: micro_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, control-word width.
REQ-002 SHALL have parameter ADDR_W, default 6, micro-address width.
REQ-003 SHALL have parameter MUL_BEATS, default 4, number of control-word issues for the MUL entry; legal range 1..255.
REQ-004 SHALL have parameter MUL_IDX, default 31, micro-address of MUL; parameter COPY_IDX, default 32, micro-address of MEMCOPY; parameter MAX_IDX, default 32, highest valid micro-address.
REQ-005 SHALL have ports clk (input, 1, clock) and rst_n (input, 1, reset); one clock; reset is asynchronous and active-low.
REQ-006 instr_valid  input  1  decoded instruction index available.
REQ-007 instr_ready  output  1  sequencer accepts instr_idx/copy_len.
REQ-008 instr_idx  input  ADDR_W  micro-address of the decoded instruction.
REQ-009 copy_len  input  8  MEMCOPY beat count, sampled on acceptance.
REQ-010 uaddr  output  ADDR_W  address driven to micro-instruction memory.
REQ-011 udata  input  WIDTH  combinational control word returned for uaddr.
REQ-012 ctrl_valid  output  1  ctrl_word valid to datapath.
REQ-013 ctrl_ready  input  1  datapath consumes ctrl_word.
REQ-014 ctrl_word  output  WIDTH  registered control word.
REQ-015 beat_idx  output  8  zero-based index of current beat.
REQ-016 ctrl_last  output  1  current beat is the final beat.
REQ-017 illegal  output  1  one-cycle pulse on out-of-range index.

Function
REQ-018 SHALL implement states IDLE, FETCH, ISSUE; instr_ready SHALL be 1 only in IDLE.
REQ-019 In IDLE, an accept (instr_valid && instr_ready at an edge) SHALL latch instr_idx into uaddr, set the beat count (MUL_BEATS for MUL_IDX, copy_len for COPY_IDX, 1 otherwise), clear beat_idx, and move to FETCH.
REQ-020 In FETCH, the edge SHALL capture udata into ctrl_word and move to ISSUE; ctrl_valid SHALL be 1 in the cycle after that edge (two edges after accept).
REQ-021 In ISSUE, ctrl_valid SHALL be 1; ctrl_word, beat_idx, and ctrl_last SHALL be held stable while ctrl_valid && !ctrl_ready.
REQ-022 ctrl_last SHALL equal (beat_idx == beat count - 1) while ctrl_valid=1, and 0 otherwise.
REQ-023 On a handshake that is not the last beat, the sequencer SHALL stay in ISSUE, increment beat_idx, keep ctrl_word, and keep ctrl_valid=1 with no gap cycle.
REQ-024 On the last-beat handshake, the sequencer SHALL go to IDLE and deassert ctrl_valid the next cycle.
REQ-025 COPY_IDX with copy_len=0 SHALL still pass through FETCH, then return to IDLE without asserting ctrl_valid.
REQ-026 An accepted instr_idx > MAX_IDX SHALL not enter FETCH and SHALL pulse illegal for exactly one cycle after the accept edge; the sequencer SHALL remain in IDLE (see REQ-030).
REQ-027 uaddr SHALL hold the last accepted legal index until the next accept.
REQ-028 Back-to-back: the next instruction SHALL be accepted no earlier than the IDLE cycle following the last-beat handshake.

Reset
REQ-029 While rst_n=0, the block SHALL force state IDLE, uaddr=0, ctrl_word=0, ctrl_valid=0, beat_idx=0, ctrl_last=0, illegal=0, instr_ready=0; instr_ready SHALL be 1 from the first clock edge after deassertion. Reset asserted in FETCH or mid-ISSUE SHALL abandon the sequence, and no beat SHALL be issued afterwards.

Configuration
REQ-030 Macro USEQ_RANGE_CHECK_EN: when defined, REQ-026 applies; when undefined, illegal SHALL be tied 0 and any index SHALL be treated as a normal single-beat instruction fetched from uaddr.

Verification
REQ-031 Accept idx 0 with ROM model attached and ctrl_ready=1 -> ctrl_word=0x1000 with ctrl_valid for one cycle, two edges after accept; ctrl_last=1; beat_idx=0.
REQ-032 Accept idx 19 with ctrl_ready=0 for 3 cycles, then 1 -> ctrl_word=0xD801 held stable for 4 cycles; single handshake; then IDLE.
REQ-033 Accept idx 31 (MUL_BEATS=4) with ctrl_ready=1 -> 4 consecutive beats of 0x1340, beat_idx 0,1,2,3, ctrl_last only on beat 3.
REQ-034 Accept idx 32 with copy_len=3, ctrl_ready toggling 1,0,1,0,1 -> three beats of 0x0C07; copy_len=0 -> no ctrl_valid, instr_ready returns after 2 cycles.
REQ-035 Accept idx 40 -> illegal pulses one cycle, no ctrl_valid, instr_ready stays 1 (macro on); macro off -> illegal=0 and one beat issued.
REQ-036 Drop rst_n during beat 2 of MUL -> all outputs 0 immediately; after release, no further beats; instr_ready=1.
